module_bin_bcd: RTL
===================

Name: module_bin_bcd

Overview:
Iterative binary-to-BCD converter (shift-and-add-3, "double dabble"). It produces the four BCD digits and the `listo` strobe consumed by the 7-segment decoder `module_seg`. It sits between the arithmetic/capture logic, which supplies a binary value, and the display path. It accepts one conversion request at a time and reports completion with a single-cycle `listo` pulse.

Parameters:
WIDTH, 14, bit width of `bin_input`; legal range 4..14.
MAX_VAL, 9999, saturation limit; any input above it is converted as MAX_VAL.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
bin_input  input  WIDTH  unsigned binary value to convert.
inicio  input  1  conversion request; sampled only in IDLE.
ocupado  output  1  high while a conversion is in progress.
listo  output  1  one-cycle pulse when new digits are valid.
unidades  output  4  BCD units digit.
decenas  output  4  BCD tens digit.
centenas  output  4  BCD hundreds digit.
milesimas  output  4  BCD thousands digit.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ocupado=0, listo=0.
  - All four digit outputs = 4'd0.
  - Shift register and iteration counter are cleared.
- Release of reset is synchronous to clk.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If inicio=1 at rising edge N, capture min(bin_input, MAX_VAL) into a WIDTH-bit shift register.
  - Clear the 16-bit BCD scratch register and load the counter with WIDTH.
  - ocupado goes 1 from edge N; next state is SHIFT.
  - If inicio=0, stay in IDLE.
- SHIFT (one iteration per clock):
  - For each BCD nibble of the scratch register, add 3 if the nibble is >= 5.
  - Then shift {scratch, binreg} left by one.
  - Decrement the counter.
  - When the counter reaches 0 after the shift (edge N+WIDTH), go to DONE.
- DONE (edge N+WIDTH+1):
  - Copy scratch nibbles [3:0], [7:4], [11:8], [15:12] to unidades, decenas, centenas, milesimas.
  - listo=1 for exactly this cycle; ocupado=0.
  - Next state is IDLE.
- Latency: inicio sampled at edge N gives listo high during the cycle after edge N+WIDTH+1, i.e. WIDTH+1 cycles (15 cycles for WIDTH=14).
- Digit outputs change only at the DONE edge and hold until the next DONE or reset. Intermediate scratch values are never visible.
- inicio while ocupado=1 or in DONE is ignored; the request is not queued.
- inicio held high continuously restarts a conversion at the first IDLE edge after DONE. Back-to-back throughput is one result per WIDTH+2 cycles.
- bin_input is sampled only at the accepting edge; later changes do not affect the current result.
- Saturation: any value > MAX_VAL yields digits 9,9,9,9.
- Add-3 correction uses 4-bit arithmetic per nibble. Carries never cross nibbles because corrected values are <= 12.
- Reset mid-conversion aborts immediately. Outputs return to 0 and no listo is emitted.

Optional Feature:
- Macro: DESBORDE_FLAG_EN.
- When defined:
  - Adds output port `desborde` (1 bit).
  - It is registered at the DONE edge: 1 if the captured input exceeded MAX_VAL, else 0.
  - It holds until the next DONE; reset value is 0.
  - Saturation behaviour is unchanged.
- When undefined: no `desborde` port and no related logic; saturation is silent.

Test Plan:
1. rst=0 for 2 cycles, then release, inicio=0 -> all digits 0, ocupado=0, listo=0 throughout.
2. bin_input=7609, inicio=1 for one cycle at edge N:
   - ocupado=1 from N.
   - listo pulses one cycle after edge N+15.
   - Digits become milesimas=7, centenas=6, decenas=0, unidades=9.
3. Back-to-back 3193 then 94, each with a one-cycle inicio once ocupado=0:
   - First result: 3,1,9,3.
   - Second result: 0,0,9,4.
   - Exactly one listo pulse per conversion; digits stable between pulses.
4. bin_input=12000 (and 16383) -> 9,9,9,9. With DESBORDE_FLAG_EN defined, desborde=1. A following input of 0 gives 0,0,0,0 and desborde=0.
5. Start a conversion of 5555; at edge N+3 pulse inicio with bin_input=1234 -> the second request is ignored, the result is 5,5,5,5, and only one listo occurs.
6. Start a conversion of 4321 (after a completed 7609); assert rst=0 mid-SHIFT at a non-edge time -> outputs go to 0 immediately, and no listo occurs after release. A fresh request for 4321 then gives 4,3,2,1.

Source files
------------

// File: rtl/module_bin_bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3) feeding the 7-segment path.
// Optional build macro DESBORDE_FLAG_EN adds the registered `desborde` overflow flag.
module module_bin_bcd #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_input,
    input  logic             inicio,
    output logic             ocupado,
    output logic             listo,
    output logic [3:0]       unidades,
    output logic [3:0]       decenas,
    output logic [3:0]       centenas,
    output logic [3:0]       milesimas,
`ifdef DESBORDE_FLAG_EN
    output logic             desborde,
`endif
    output logic [1:0]       estado_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [31:0] MAX_U = 32'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // Handshake: inicio is a request sampled only in IDLE; ocupado is high from the
    // accepting edge until the DONE edge; listo is a one-cycle strobe marking new digits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;
    logic [15:0]      digits_q, digits_d;
    logic             over_range;
    logic [15:0]      corrected;
`ifdef DESBORDE_FLAG_EN
    logic             ovf_q, ovf_d;
    logic             desborde_q, desborde_d;
`endif

    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign over_range = 32'(bin_input) > MAX_U;
    assign corrected  = add3(scratch_q);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ocupado_d = ocupado_q;
        listo_d   = 1'b0;
        digits_d  = digits_q;
`ifdef DESBORDE_FLAG_EN
        ovf_d      = ovf_q;
        desborde_d = desborde_q;
`endif
        case (state_q)
            IDLE: begin
                if (inicio) begin
                    bin_d     = over_range ? MAX_W : bin_input;
                    scratch_d = 16'd0;
                    cnt_d     = CNT_W'(WIDTH);
                    ocupado_d = 1'b1;
                    state_d   = SHIFT;
`ifdef DESBORDE_FLAG_EN
                    ovf_d     = over_range;
`endif
                end
            end
            SHIFT: begin
                // Correct first, then shift the binary MSB into the BCD scratch.
                {scratch_d, bin_d} = {corrected, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d  = scratch_q;
                listo_d   = 1'b1;
                ocupado_d = 1'b0;
                state_d   = IDLE;
`ifdef DESBORDE_FLAG_EN
                desborde_d = ovf_q;
`endif
            end
            default: begin
                state_d   = IDLE;
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= 16'd0;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            digits_q  <= 16'd0;
`ifdef DESBORDE_FLAG_EN
            ovf_q      <= 1'b0;
            desborde_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
            digits_q  <= digits_d;
`ifdef DESBORDE_FLAG_EN
            ovf_q      <= ovf_d;
            desborde_q <= desborde_d;
`endif
        end
    end

    assign ocupado    = ocupado_q;
    assign listo      = listo_q;
    assign unidades   = digits_q[3:0];
    assign decenas    = digits_q[7:4];
    assign centenas   = digits_q[11:8];
    assign milesimas  = digits_q[15:12];
    assign estado_dbg = state_q;
`ifdef DESBORDE_FLAG_EN
    assign desborde   = desborde_q;
`endif

endmodule
